// File: rtl/mem_bus_scheduler.sv
// Shared main-memory bus scheduler for two cache controllers.
// Serialises requests through a four-state FSM, arbitrates ties round-robin,
// and emits a snoop invalidate to the other cache whenever a write completes.
//
// Handshake: a requester raises req_x with we_x/addr_x/wdata_x stable and keeps
// it high until it samples done_x high, then drops it on that same edge. The
// scheduler latches the request in IDLE; later changes to req_x are ignored
// until the transaction's DONE cycle has passed.
module mem_bus_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       we_1,
    input  logic       we_2,
    input  logic [7:0] addr_1,
    input  logic [7:0] addr_2,
    input  logic [7:0] wdata_1,
    input  logic [7:0] wdata_2,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic       done_1,
    output logic       done_2,
    output logic [7:0] rdata_1,
    output logic [7:0] rdata_2,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       snoop_valid_1,
    output logic       snoop_valid_2,
    output logic [7:0] snoop_addr,
    output logic       bus_busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    // Requester ids are encoded as one bit: 0 = requester 1, 1 = requester 2.
    logic       last_q, last_d;
    logic       win_q, win_d;
    logic       we_q, we_d;
    logic       gnt_1_q, gnt_1_d;
    logic       gnt_2_q, gnt_2_d;
    logic       done_1_q, done_1_d;
    logic       done_2_q, done_2_d;
    logic [7:0] rdata_1_q, rdata_1_d;
    logic [7:0] rdata_2_q, rdata_2_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       mem_we_q, mem_we_d;
    logic       snoop_valid_1_q, snoop_valid_1_d;
    logic       snoop_valid_2_q, snoop_valid_2_d;
    logic [7:0] snoop_addr_q, snoop_addr_d;
    logic       bus_busy_q, bus_busy_d;
    logic       pick_2;

    // On a tie the requester that was not served last wins; otherwise whoever asks.
    assign pick_2 = (req_1 && req_2) ? ~last_q : req_2;

    // Next-state and next-output computation for every register.
    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        win_d           = win_q;
        we_d            = we_q;
        gnt_1_d         = gnt_1_q;
        gnt_2_d         = gnt_2_q;
        done_1_d        = 1'b0;
        done_2_d        = 1'b0;
        rdata_1_d       = rdata_1_q;
        rdata_2_d       = rdata_2_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_we_d        = 1'b0;
        snoop_valid_1_d = 1'b0;
        snoop_valid_2_d = 1'b0;
        snoop_addr_d    = snoop_addr_q;
        bus_busy_d      = bus_busy_q;
        case (state_q)
            S_IDLE: begin
                if (req_1 || req_2) begin
                    state_d     = S_ACCESS;
                    win_d       = pick_2;
                    we_d        = pick_2 ? we_2 : we_1;
                    gnt_1_d     = ~pick_2;
                    gnt_2_d     = pick_2;
                    mem_addr_d  = pick_2 ? addr_2 : addr_1;
                    mem_wdata_d = pick_2 ? wdata_2 : wdata_1;
                    mem_we_d    = pick_2 ? we_2 : we_1;
                    bus_busy_d  = 1'b1;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    // Write lands this cycle; finish now and invalidate the other cache.
                    state_d         = S_DONE;
                    done_1_d        = ~win_q;
                    done_2_d        = win_q;
                    snoop_valid_1_d = win_q;
                    snoop_valid_2_d = ~win_q;
                    snoop_addr_d    = mem_addr_q;
                end else begin
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                // Memory data is registered, so it is valid now, one cycle after the address.
                state_d  = S_DONE;
                done_1_d = ~win_q;
                done_2_d = win_q;
                if (win_q) begin
                    rdata_2_d = mem_rdata;
                end else begin
                    rdata_1_d = mem_rdata;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                last_d     = win_q;
                gnt_1_d    = 1'b0;
                gnt_2_d    = 1'b0;
                bus_busy_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_q          <= 1'b1;
            win_q           <= 1'b0;
            we_q            <= 1'b0;
            gnt_1_q         <= 1'b0;
            gnt_2_q         <= 1'b0;
            done_1_q        <= 1'b0;
            done_2_q        <= 1'b0;
            rdata_1_q       <= 8'h00;
            rdata_2_q       <= 8'h00;
            mem_addr_q      <= 8'h00;
            mem_wdata_q     <= 8'h00;
            mem_we_q        <= 1'b0;
            snoop_valid_1_q <= 1'b0;
            snoop_valid_2_q <= 1'b0;
            snoop_addr_q    <= 8'h00;
            bus_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            win_q           <= win_d;
            we_q            <= we_d;
            gnt_1_q         <= gnt_1_d;
            gnt_2_q         <= gnt_2_d;
            done_1_q        <= done_1_d;
            done_2_q        <= done_2_d;
            rdata_1_q       <= rdata_1_d;
            rdata_2_q       <= rdata_2_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_we_q        <= mem_we_d;
            snoop_valid_1_q <= snoop_valid_1_d;
            snoop_valid_2_q <= snoop_valid_2_d;
            snoop_addr_q    <= snoop_addr_d;
            bus_busy_q      <= bus_busy_d;
        end
    end

    assign gnt_1         = gnt_1_q;
    assign gnt_2         = gnt_2_q;
    assign done_1        = done_1_q;
    assign done_2        = done_2_q;
    assign rdata_1       = rdata_1_q;
    assign rdata_2       = rdata_2_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_we        = mem_we_q;
    assign snoop_valid_1 = snoop_valid_1_q;
    assign snoop_valid_2 = snoop_valid_2_q;
    assign snoop_addr    = snoop_addr_q;
    assign bus_busy      = bus_busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench for mem_bus_scheduler: a table of transactions with
// hand-computed winner, latency and read data, plus a reset-during-read sequence.
module tb_mem_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_1 = 1'b0, req_2 = 1'b0;
    logic       we_1 = 1'b0, we_2 = 1'b0;
    logic [7:0] addr_1 = 8'h00, addr_2 = 8'h00;
    logic [7:0] wdata_1 = 8'h00, wdata_2 = 8'h00;
    logic       gnt_1, gnt_2, done_1, done_2;
    logic [7:0] rdata_1, rdata_2, mem_addr, mem_wdata, snoop_addr;
    logic       mem_we, snoop_valid_1, snoop_valid_2, bus_busy;
    logic [7:0] mem_rdata = 8'h00;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    mem_bus_scheduler dut (
        .clk(clk), .rst(rst),
        .req_1(req_1), .req_2(req_2), .we_1(we_1), .we_2(we_2),
        .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
        .gnt_1(gnt_1), .gnt_2(gnt_2), .done_1(done_1), .done_2(done_2),
        .rdata_1(rdata_1), .rdata_2(rdata_2),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .snoop_valid_1(snoop_valid_1), .snoop_valid_2(snoop_valid_2),
        .snoop_addr(snoop_addr), .bus_busy(bus_busy), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Shared memory model: registered read, write on mem_we; preset to addr ^ 0x5A
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic       do_reset;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       r2, w2;
        logic [7:0] a2, d2;
        logic       drop;
        int         win;
        int         lat;
        logic [7:0] rd;
    } txn_t;

    function automatic txn_t mk(input logic rs, input logic r1, input logic w1,
                                input logic [7:0] a1, input logic [7:0] d1,
                                input logic r2, input logic w2,
                                input logic [7:0] a2, input logic [7:0] d2,
                                input logic drop, input int win, input int lat,
                                input logic [7:0] rd);
        txn_t t;
        t.do_reset = rs; t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
        t.r2 = r2; t.w2 = w2; t.a2 = a2; t.d2 = d2;
        t.drop = drop; t.win = win; t.lat = lat; t.rd = rd;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous reset pulse, entered and left at a falling edge
    task automatic do_reset();
        rst = 1'b1;
        req_1 = 1'b0; req_2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver + per-cycle checker for one transaction; ends at a falling edge in IDLE
    task automatic run_txn(input txn_t t);
        int         k;
        int         done_k;
        int         we_cnt;
        logic       exp_we;
        logic [7:0] exp_a, exp_d;
        logic       g_w, g_l, d_w, d_l, s_w, s_l;
        logic [7:0] rd_w;
        if (t.do_reset) do_reset();
        req_1 = t.r1; we_1 = t.w1; addr_1 = t.a1; wdata_1 = t.d1;
        req_2 = t.r2; we_2 = t.w2; addr_2 = t.a2; wdata_2 = t.d2;
        exp_we = (t.win == 1) ? t.w1 : t.w2;
        exp_a  = (t.win == 1) ? t.a1 : t.a2;
        exp_d  = (t.win == 1) ? t.d1 : t.d2;
        done_k = 0;
        we_cnt = 0;
        @(posedge clk);
        k = 1;
        while (k <= 8 && done_k == 0) begin
            @(negedge clk);
            if (t.drop && k == 1) begin
                if (t.win == 1) req_1 = 1'b0; else req_2 = 1'b0;
            end
            g_w  = (t.win == 1) ? gnt_1 : gnt_2;
            g_l  = (t.win == 1) ? gnt_2 : gnt_1;
            d_w  = (t.win == 1) ? done_1 : done_2;
            d_l  = (t.win == 1) ? done_2 : done_1;
            s_w  = (t.win == 1) ? snoop_valid_1 : snoop_valid_2;
            s_l  = (t.win == 1) ? snoop_valid_2 : snoop_valid_1;
            rd_w = (t.win == 1) ? rdata_1 : rdata_2;
            check("gnt_exclusive", gnt_1 & gnt_2, 8'd0);
            check("gnt_winner", g_w, 8'd1);
            check("gnt_loser", g_l, 8'd0);
            check("done_loser", d_l, 8'd0);
            check("bus_busy", bus_busy, 8'd1);
            if (k == 1) check("mem_addr", mem_addr, exp_a);
            if (mem_we) begin
                we_cnt++;
                check("mem_we_addr", mem_addr, exp_a);
                check("mem_we_data", mem_wdata, exp_d);
            end
            if (d_w) begin
                done_k = k;
                check("latency", 8'(k), 8'(t.lat));
                check("snoop_other", s_l, 8'(exp_we));
                check("snoop_self", s_w, 8'd0);
                if (exp_we) check("snoop_addr", snoop_addr, exp_a);
                else        check("rdata", rd_w, t.rd);
                if (t.win == 1) req_1 = 1'b0; else req_2 = 1'b0;
            end else begin
                check("snoop_idle", snoop_valid_1 | snoop_valid_2, 8'd0);
            end
            k++;
        end
        if (done_k == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done for requester %0d within 8 cycles", t.win);
        end
        check("mem_we_count", 8'(we_cnt), 8'(exp_we));
        @(negedge clk);
        check("idle_done", done_1 | done_2, 8'd0);
        check("idle_gnt", gnt_1 | gnt_2, 8'd0);
        check("idle_busy", bus_busy, 8'd0);
        check("idle_snoop", snoop_valid_1 | snoop_valid_2, 8'd0);
        check("idle_state", state_dbg, 8'd0);
    endtask

    txn_t tbl[12];

    initial begin
        // rst, r1,w1,a1,d1, r2,w2,a2,d2, drop, winner, latency, read data
        tbl[0]  = mk(0, 1,1,8'h3C,8'hA5, 0,0,8'h00,8'h00, 0, 1, 2, 8'h00);
        tbl[1]  = mk(0, 0,1,8'h3C,8'hA5, 1,0,8'h3C,8'h00, 0, 2, 3, 8'hA5);
        tbl[2]  = mk(1, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0, 1, 3, 8'h4A);
        tbl[3]  = mk(0, 0,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0, 2, 3, 8'h7A);
        tbl[4]  = mk(0, 1,1,8'h40,8'h11, 1,0,8'h40,8'h00, 0, 1, 2, 8'h00);
        tbl[5]  = mk(0, 1,1,8'h40,8'h22, 1,0,8'h40,8'h00, 0, 2, 3, 8'h11);
        tbl[6]  = mk(0, 1,1,8'h40,8'h22, 1,0,8'h40,8'h00, 0, 1, 2, 8'h00);
        tbl[7]  = mk(0, 1,1,8'h40,8'h33, 1,0,8'h40,8'h00, 0, 2, 3, 8'h22);
        tbl[8]  = mk(0, 1,1,8'h40,8'h33, 1,0,8'h40,8'h00, 0, 1, 2, 8'h00);
        tbl[9]  = mk(0, 1,1,8'h55,8'h77, 1,0,8'h40,8'h00, 0, 2, 3, 8'h33);
        tbl[10] = mk(0, 1,1,8'h55,8'h77, 0,0,8'h40,8'h00, 1, 1, 2, 8'h00);
        tbl[11] = mk(0, 0,0,8'h00,8'h00, 1,0,8'h55,8'h00, 0, 2, 3, 8'h77);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_state", state_dbg, 8'd0);
        check("rst_busy", bus_busy, 8'd0);
        check("rst_gnt", {gnt_1, gnt_2}, 8'd0);
        check("rst_done", {done_1, done_2}, 8'd0);
        check("rst_rdata_1", rdata_1, 8'h00);
        check("rst_rdata_2", rdata_2, 8'h00);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_we", mem_we, 8'd0);
        check("rst_snoop", {snoop_valid_1, snoop_valid_2}, 8'd0);

        for (int i = 0; i < 12; i++) run_txn(tbl[i]);
        check("early_drop_mem", mem[8'h55], 8'h77);

        // Reset during RDWAIT of a read: aborts with no done, outputs cleared
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h20; req_2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_access", state_dbg, 8'd1);
        @(negedge clk);
        check("abort_rdwait", state_dbg, 8'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_1 = 1'b0;
        check("abort_state", state_dbg, 8'd0);
        check("abort_busy", bus_busy, 8'd0);
        check("abort_done", {done_1, done_2}, 8'd0);
        check("abort_gnt", {gnt_1, gnt_2}, 8'd0);
        check("abort_rdata_1", rdata_1, 8'h00);
        check("abort_rdata_2", rdata_2, 8'h00);
        check("abort_mem_we", mem_we, 8'd0);
        check("abort_snoop", {snoop_valid_1, snoop_valid_2}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {done_1, done_2}, 8'd0);
            check("abort_stay_idle", state_dbg, 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_scheduler.md
MEM_BUS_SCHEDULER -- requirements
Module: mem_bus_scheduler

Interface
REQ-001 Reset rst is synchronous and active-high; clock is clk.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_1, req_2  input  1  bus request from cache controller 1 or 2; held high until done_x.
REQ-005 we_1, we_2  input  1  request type: 1 = write, 0 = read; stable while req_x is high.
REQ-006 addr_1, addr_2  input  8  memory address; stable while req_x is high.
REQ-007 wdata_1, wdata_2  input  8  write data; stable while req_x is high.
REQ-008 gnt_1, gnt_2  output  1  grant; high from ACCESS through DONE for the winning requester.
REQ-009 done_1, done_2  output  1  one-cycle completion pulse.
REQ-010 rdata_1, rdata_2  output  8  read data; valid while done_x is high and held until that requester's next read completes.
REQ-011 mem_addr  output  8  address to the shared main memory.
REQ-012 mem_wdata  output  8  write data to the shared main memory.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_rdata  input  8  memory read data, registered, valid one cycle after mem_addr is presented.
REQ-015 snoop_valid_1, snoop_valid_2  output  1  one-cycle invalidate pulse to cache 1 or 2.
REQ-016 snoop_addr  output  8  address being invalidated.
REQ-017 bus_busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The state machine has four states: IDLE, ACCESS, RDWAIT and DONE.
REQ-019 IDLE: with no request pending, the block stays in IDLE.
REQ-020 IDLE: with any req_x high at the edge, the block latches the winner's id, we, addr and wdata and moves to ACCESS.
REQ-021 Arbitration is round-robin on a last_served register.
  - When both requests are high, the requester not equal to last_served wins.
  - last_served resets to 2, so requester 1 wins the first tie.
REQ-022 ACCESS drives the latched transaction onto the memory port.
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_we = 1 for a write, 0 for a read.
  - Next state is DONE for a write and RDWAIT for a read.
REQ-023 RDWAIT: mem_we = 0 and mem_addr is held; at the edge leaving RDWAIT, mem_rdata is captured into rdata_x of the winner; next state is DONE.
REQ-024 DONE:
  - done_x is high for exactly one cycle.
  - last_served is updated to the winner.
  - Next state is IDLE.
REQ-025 Latency from the edge that samples req in IDLE to done_x high: write 2 cycles, read 3 cycles.
REQ-026 mem_we is high only during ACCESS of a write, so each write occurs exactly once.
REQ-027 A write completing in DONE raises the other requester's snoop_valid for that same cycle, with snoop_addr = the write address. A read never raises snoop_valid.
REQ-028 Outside a write's DONE cycle, snoop_valid_1 = snoop_valid_2 = 0; snoop_addr holds its last value.
REQ-029 Requesters deassert req_x at the edge on which they sample done_x high; a req_x still high in the following IDLE is a new request.
REQ-030 A req_x deasserted mid-transaction is ignored; the transaction completes and done_x still pulses.
REQ-031 When gnt, done and snoop are idle, gnt_x, done_x and snoop_valid_x are 0, and gnt_1 and gnt_2 are never high together.
REQ-032 The loser of a simultaneous request is served in the next transaction; no requester waits more than one transaction.
REQ-033 A write followed by a read of the same address by the other requester returns the new data; ordering is guaranteed by serialization.

Reset
REQ-034 At reset, state = IDLE and last_served = 2.
REQ-035 At reset, all output registers are 0: gnt_x, done_x, rdata_x, mem_addr, mem_wdata, mem_we, snoop_valid_x, snoop_addr, bus_busy.
REQ-036 Reset mid-transaction aborts the transaction: no done_x or snoop pulse, and mem_we = 0 from the next cycle.

Verification
REQ-037 Single write: req_1 = 1, we_1 = 1, addr_1 = 0x3C, wdata_1 = 0xA5 -> mem_we pulses once with mem_addr = 0x3C; done_1 pulses 2 cycles after sampling; snoop_valid_2 = 1 and snoop_addr = 0x3C in the same cycle.
REQ-038 Single read: req_2 = 1, we_2 = 0, addr_2 = 0x3C after the write in REQ-037 -> done_2 pulses 3 cycles after sampling; rdata_2 = 0xA5; no snoop pulse.
REQ-039 Simultaneous after reset: both requests are reads, to 0x10 and 0x20 -> requester 1 is served first, then requester 2; gnt_1 and gnt_2 are never high together.
REQ-040 Continuous contention: both requests held high for 6 transactions -> grants strictly alternate 1, 2, 1, 2, 1, 2.
REQ-041 Reset mid-operation: rst asserted during RDWAIT -> next cycle state is IDLE, bus_busy = 0, no done pulse; rdata is unchanged from 0.
REQ-042 Early req drop: req_1 falls during ACCESS of a write -> the write still completes and done_1 still pulses.
